// File: rtl/spi_pkg.sv
// Shared types and SPI mode decoding for the chip-select SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    CS_INACTIVE
  } cs_state_t;

  function automatic logic cpol(input int unsigned mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input int unsigned mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_master_byte.sv
// Single-byte SPI engine: SCK generation, MSB-first MOSI shift and MISO capture.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE          = 3,
  parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_dv_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       rx_dv_o,
  output logic [7:0] rx_byte_o,
  output logic       done_o
);

  localparam logic        CPOL = cpol(SPI_MODE);
  localparam logic        CPHA = cpha(SPI_MODE);
  localparam int unsigned HW   = $clog2(CLKS_PER_HALF_BIT);

  logic [4:0]    edges_q, edges_d;
  logic [HW-1:0] half_q, half_d;
  logic [7:0]    tx_q, tx_d;
  logic [6:0]    rx_q, rx_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          rx_dv_q, rx_dv_d;
  logic          done_q, done_d;
  logic          sck_edge, leading, drive_edge, sample_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      edges_q   <= '0;
      half_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_byte_q <= '0;
      sck_q     <= CPOL;
      mosi_q    <= 1'b0;
      rx_dv_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      edges_q   <= edges_d;
      half_q    <= half_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_byte_q <= rx_byte_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      rx_dv_q   <= rx_dv_d;
      done_q    <= done_d;
    end
  end

  // edges_q counts remaining SCK edges; an even count means the next edge is leading
  always_comb begin
    edges_d     = edges_q;
    half_d      = half_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rx_byte_d   = rx_byte_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rx_dv_d     = 1'b0;
    done_d      = 1'b0;
    sck_edge    = (edges_q != 5'd0) && (half_q == HW'(CLKS_PER_HALF_BIT - 1));
    leading     = ~edges_q[0];
    drive_edge  = CPHA ? leading : (!leading && edges_q != 5'd1);
    sample_edge = CPHA ? !leading : leading;

    if (tx_dv_i) begin
      edges_d = 5'd16;
      half_d  = '0;
      if (CPHA) begin
        tx_d = tx_byte_i;
      end else begin
        mosi_d = tx_byte_i[7];
        tx_d   = {tx_byte_i[6:0], 1'b0};
      end
    end else if (edges_q != 5'd0) begin
      if (sck_edge) begin
        half_d  = '0;
        edges_d = edges_q - 5'd1;
        sck_d   = ~sck_q;
        if (drive_edge) begin
          mosi_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
        if (sample_edge) begin
          rx_d = {rx_q[5:0], miso_i};
          if (edges_q == (CPHA ? 5'd1 : 5'd2)) begin
            rx_byte_d = {rx_q, miso_i};
            rx_dv_d   = 1'b1;
          end
        end
        if (edges_q == 5'd1) done_d = 1'b1;
      end else begin
        half_d = half_q + HW'(1);
      end
    end
  end

  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;
  assign rx_dv_o   = rx_dv_q;
  assign rx_byte_o = rx_byte_q;
  assign done_o    = done_q;

endmodule

// File: rtl/spi_master_w_cs.sv
// SPI master with automatic active-low chip select spanning a programmed byte burst.
module spi_master_w_cs
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE          = 3,
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter int unsigned MAX_BYTES_PER_CS  = 2,
  parameter int unsigned CS_INACTIVE_CLKS  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] i_MOSI_Count,
  input  logic [7:0]                            i_MOSI_Byte,
  input  logic                                  i_MOSI_DV,
  output logic                                  o_MOSI_Ready,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_MISO_Count,
  output logic                                  o_MISO_DV,
  output logic [7:0]                            o_MISO_Byte,
  output logic                                  SCK,
  input  logic                                  MISO,
  output logic                                  MOSI,
  output logic                                  CS_L
);

  localparam int unsigned CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int unsigned IW = $clog2(CS_INACTIVE_CLKS + 1);

  cs_state_t     state_q, state_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] miso_count_q, miso_count_d;
  logic [IW-1:0] inact_q, inact_d;
  logic          cs_l_q, cs_l_d;
  logic          ready_q, ready_d;
  logic          accept, byte_done, rx_dv;

  assign accept = i_MOSI_DV & ready_q;

  spi_master_byte #(
    .SPI_MODE          (SPI_MODE),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
  ) u_byte (
    .clk       (clk),
    .rst       (rst),
    .tx_dv_i   (accept),
    .tx_byte_i (i_MOSI_Byte),
    .miso_i    (MISO),
    .sck_o     (SCK),
    .mosi_o    (MOSI),
    .rx_dv_o   (rx_dv),
    .rx_byte_o (o_MISO_Byte),
    .done_o    (byte_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      miso_count_q <= '0;
      inact_q      <= '0;
      cs_l_q       <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      miso_count_q <= miso_count_d;
      inact_q      <= inact_d;
      cs_l_q       <= cs_l_d;
      ready_q      <= ready_d;
    end
  end

  // Burst sequencing; a zero count opens a one-byte burst
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    inact_d     = inact_q;
    cs_l_d      = cs_l_q;
    ready_d     = ready_q;

    case (state_q)
      IDLE: begin
        cs_l_d  = 1'b1;
        ready_d = 1'b1;
        if (accept) begin
          remaining_d = (i_MOSI_Count == '0) ? '0 : i_MOSI_Count - CW'(1);
          cs_l_d      = 1'b0;
          ready_d     = 1'b0;
          state_d     = TRANSFER;
        end
      end
      TRANSFER: begin
        cs_l_d = 1'b0;
        if (accept) begin
          remaining_d = remaining_q - CW'(1);
          ready_d     = 1'b0;
        end else if (byte_done) begin
          if (remaining_q != '0) begin
            ready_d = 1'b1;
          end else begin
            cs_l_d  = 1'b1;
            ready_d = 1'b0;
            inact_d = '0;
            state_d = CS_INACTIVE;
          end
        end
      end
      CS_INACTIVE: begin
        cs_l_d  = 1'b1;
        ready_d = 1'b0;
        if (inact_q == IW'(CS_INACTIVE_CLKS - 1)) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          inact_d = inact_q + IW'(1);
        end
      end
      default: begin
        cs_l_d  = 1'b1;
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    miso_count_d = miso_count_q;
    if (cs_l_d) miso_count_d = '0;
    else if (rx_dv) miso_count_d = miso_count_q + CW'(1);
  end

  assign o_MOSI_Ready = ready_q;
  assign o_MISO_Count = miso_count_q;
  assign o_MISO_DV    = rx_dv;
  assign CS_L         = cs_l_q;

endmodule

// File: tb/tb_spi_master_w_cs.sv
// Directed bench: one master per SPI mode, each with MOSI looped back to MISO.
module tb_spi_master_w_cs;

  localparam int unsigned CPHW = 4;
  localparam int unsigned MAXB = 2;
  localparam int unsigned GAP  = 10;
  localparam int unsigned CW   = 2;
  localparam int          TMO  = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] mosi_count [4];
  logic [7:0]    mosi_byte  [4];
  logic          mosi_dv    [4];
  logic          ready      [4];
  logic [CW-1:0] miso_count [4];
  logic          miso_dv    [4];
  logic [7:0]    miso_byte  [4];
  logic          sck        [4];
  logic          mosi       [4];
  logic          cs_l       [4];

  int n_cmp = 0;
  int n_err = 0;
  int rxcnt   [4];
  int edges   [4];
  int gap     [4];
  int bad_gap [4];
  logic sck_prev [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_w_cs #(
      .SPI_MODE          (g),
      .CLKS_PER_HALF_BIT (CPHW),
      .MAX_BYTES_PER_CS  (MAXB),
      .CS_INACTIVE_CLKS  (GAP)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_MOSI_Count (mosi_count[g]),
      .i_MOSI_Byte  (mosi_byte[g]),
      .i_MOSI_DV    (mosi_dv[g]),
      .o_MOSI_Ready (ready[g]),
      .o_MISO_Count (miso_count[g]),
      .o_MISO_DV    (miso_dv[g]),
      .o_MISO_Byte  (miso_byte[g]),
      .SCK          (sck[g]),
      .MISO         (mosi[g]),
      .MOSI         (mosi[g]),
      .CS_L         (cs_l[g])
    );
  end

  // SCK edge counter, half-period checker and received-byte counter
  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rst) begin
        edges[m] = 0;
        gap[m]   = 0;
      end else if (sck[m] !== sck_prev[m]) begin
        if (edges[m] % 16 != 0 && gap[m] != int'(CPHW)) bad_gap[m]++;
        edges[m]++;
        gap[m] = 1;
      end else begin
        gap[m]++;
      end
      if (miso_dv[m] === 1'b1) rxcnt[m]++;
      sck_prev[m] = sck[m];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int m, input logic [7:0] b, input int cnt);
    mosi_byte[m]  = b;
    mosi_count[m] = CW'(cnt);
    mosi_dv[m]    = 1'b1;
    tick();
    mosi_dv[m]    = 1'b0;
  endtask

  task automatic wait_ready(input int m, input string tag);
    int n = 0;
    while (ready[m] !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    if (n >= TMO) check_eq({tag, "_ready_timeout"}, 32'(ready[m]), 32'd1);
  endtask

  task automatic wait_rx(input int m, input string tag, output logic [7:0] b, output logic [CW-1:0] c);
    int n = 0;
    while (miso_dv[m] !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    if (n >= TMO) check_eq({tag, "_rx_timeout"}, 32'(miso_dv[m]), 32'd1);
    b = miso_byte[m];
    c = miso_count[m];
  endtask

  // Called in the cycle the last byte's o_MISO_DV is seen (CPHA=1 only)
  task automatic check_gap(input int m, input string tag);
    int n = 0;
    int hi = 1;
    tick();
    while (ready[m] !== 1'b1 && n < 50) begin
      if (cs_l[m] !== 1'b1) hi = 0;
      n++;
      tick();
    end
    check_eq({tag, "_gap_len"}, 32'(n), 32'(GAP));
    check_eq({tag, "_gap_cs_high"}, 32'(hi), 32'd1);
  endtask

  initial begin
    logic [7:0]    rb;
    logic [CW-1:0] rc;
    int            e0, r0;

    rst = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mosi_dv[m] = 1'b0; mosi_byte[m] = 8'h00; mosi_count[m] = '0;
      rxcnt[m] = 0; bad_gap[m] = 0;
    end
    repeat (3) tick();

    // Reset state
    for (int m = 0; m < 4; m++) begin
      check_eq($sformatf("rst_sck_m%0d", m), 32'(sck[m]), 32'((m >> 1) & 1));
      check_eq($sformatf("rst_cs_m%0d", m), 32'(cs_l[m]), 32'd1);
    end
    check_eq("rst_mosi", 32'(mosi[3]), 32'd0);
    check_eq("rst_miso_byte", 32'(miso_byte[3]), 32'd0);
    check_eq("rst_miso_dv", 32'(miso_dv[3]), 32'd0);
    check_eq("rst_miso_count", 32'(miso_count[3]), 32'd0);
    check_eq("rst_ready", 32'(ready[3]), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("ready_after_rst", 32'(ready[3]), 32'd1);

    // Two-byte burst, mode 3
    send(3, 8'h37, 2);
    check_eq("burst_cs_low", 32'(cs_l[3]), 32'd0);
    wait_rx(3, "b0", rb, rc);
    check_eq("b0_byte", 32'(rb), 32'h37);
    check_eq("b0_count", 32'(rc), 32'd0);
    wait_ready(3, "b1");
    check_eq("burst_cs_held", 32'(cs_l[3]), 32'd0);
    send(3, 8'h38, 2);
    wait_rx(3, "b1", rb, rc);
    check_eq("b1_byte", 32'(rb), 32'h38);
    check_eq("b1_count", 32'(rc), 32'd1);
    check_gap(3, "burst");
    check_eq("idle_cs", 32'(cs_l[3]), 32'd1);

    // Modes 0..2: single byte, SCK shape; mode 0 also sees an ignored DV
    for (int m = 0; m < 3; m++) begin
      check_eq($sformatf("idle_sck_m%0d", m), 32'(sck[m]), 32'((m >> 1) & 1));
      e0 = edges[m];
      r0 = rxcnt[m];
      send(m, 8'hA5, 1);
      if (m == 0) begin
        repeat (3) tick();
        check_eq("busy_ready", 32'(ready[0]), 32'd0);
        send(0, 8'hFF, 1);
      end
      wait_rx(m, $sformatf("a5_m%0d", m), rb, rc);
      check_eq($sformatf("a5_byte_m%0d", m), 32'(rb), 32'hA5);
      wait_ready(m, $sformatf("a5_m%0d", m));
      repeat (4) tick();
      check_eq($sformatf("a5_edges_m%0d", m), 32'(edges[m] - e0), 32'd16);
      check_eq($sformatf("a5_halfper_m%0d", m), 32'(bad_gap[m]), 32'd0);
      check_eq($sformatf("a5_sck_end_m%0d", m), 32'(sck[m]), 32'((m >> 1) & 1));
      check_eq($sformatf("a5_rxcnt_m%0d", m), 32'(rxcnt[m] - r0), 32'd1);
    end

    // One-byte bursts: count 1 and count 0 both release CS after each byte
    send(3, 8'h11, 1);
    wait_rx(3, "c1", rb, rc);
    check_eq("c1_byte", 32'(rb), 32'h11);
    check_gap(3, "c1");
    send(3, 8'h22, 0);
    wait_rx(3, "c0", rb, rc);
    check_eq("c0_byte", 32'(rb), 32'h22);
    check_eq("c0_count", 32'(rc), 32'd0);
    check_gap(3, "c0");

    // Reset mid-byte aborts the transfer
    send(3, 8'hC3, 1);
    repeat (20) tick();
    check_eq("mid_cs_low", 32'(cs_l[3]), 32'd0);
    r0 = rxcnt[3];
    rst = 1'b1;
    tick();
    check_eq("abort_cs", 32'(cs_l[3]), 32'd1);
    check_eq("abort_sck", 32'(sck[3]), 32'd1);
    check_eq("abort_dv", 32'(miso_dv[3]), 32'd0);
    tick();
    rst = 1'b0;
    repeat (70) tick();
    check_eq("abort_no_rx", 32'(rxcnt[3] - r0), 32'd0);
    wait_ready(3, "post");
    send(3, 8'h5A, 1);
    wait_rx(3, "post", rb, rc);
    check_eq("post_byte", 32'(rb), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
